pipe_stage_sequencer: RTL and testbench

//   Upstream driver for the one-hot stage decoder: steps a 3-bit stage index

---
 rtl/pipe_stage_sequencer.sv | 133 +++++++++++++
 tb/tb_pipe_stage_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_sequencer.sv
// Stage-index sequencer feeding the one-hot stage decoder: sweeps sel through NUM_STAGES
// stages, HOLD_CYCLES clocks each, freezing on halt. Optional abort input under `SEQ_ABORT_EN.
module pipe_stage_sequencer #(
    parameter int NUM_STAGES  = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt,
`ifdef SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic [2:0] sel,
    output logic       en,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_SEL   = 3'(NUM_STAGES - 1);
    localparam logic [3:0] LAST_DWELL = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [2:0] sel_next;
    logic [3:0] dwell, dwell_next;
    logic       en_next, busy_next, done_next;
    logic       abort_req;

`ifdef SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic; abort outranks halt, and halt outranks stage advance and completion.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        dwell_next = dwell;
        en_next    = en;
        busy_next  = busy;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                en_next   = 1'b0;
                busy_next = 1'b0;
                sel_next  = 3'd0;
                if (start) begin
                    sel_next   = 3'd0;
                    dwell_next = 4'd0;
                    busy_next  = 1'b1;
                    if (halt) begin
                        state_next = FREEZE;
                        en_next    = 1'b0;
                    end else begin
                        state_next = RUN;
                        en_next    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_next = IDLE;
                    sel_next   = 3'd0;
                    dwell_next = 4'd0;
                    en_next    = 1'b0;
                    busy_next  = 1'b0;
                end else if (halt) begin
                    state_next = FREEZE;
                    en_next    = 1'b0;
                end else if (dwell == LAST_DWELL) begin
                    dwell_next = 4'd0;
                    if (sel == LAST_SEL) begin
                        state_next = IDLE;
                        sel_next   = 3'd0;
                        en_next    = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        sel_next = sel + 3'd1;
                    end
                end else begin
                    dwell_next = dwell + 4'd1;
                end
            end
            FREEZE: begin
                if (abort_req) begin
                    state_next = IDLE;
                    sel_next   = 3'd0;
                    dwell_next = 4'd0;
                    en_next    = 1'b0;
                    busy_next  = 1'b0;
                end else if (!halt) begin
                    // Resume without counting this edge, so the held dwell progress is kept.
                    state_next = RUN;
                    en_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 3'd0;
                dwell_next = 4'd0;
                en_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 3'd0;
            dwell <= 4'd0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            dwell <= dwell_next;
            en    <= en_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// Bench for pipe_stage_sequencer: a default instance and a 4-stage/3-hold instance are driven
// together and compared against a progress-count model, a fixed vector table and corner sequences.
module tb_pipe_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       abort;
    logic [2:0] sel0, sel1;
    logic       en0, en1, busy0, busy1, done0, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_sequencer dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .halt  (halt),
`ifdef SEQ_ABORT_EN
        .abort (abort),
`endif
        .sel   (sel0),
        .en    (en0),
        .busy  (busy0),
        .done  (done0)
    );

    pipe_stage_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .halt  (halt),
`ifdef SEQ_ABORT_EN
        .abort (abort),
`endif
        .sel   (sel1),
        .en    (en1),
        .busy  (busy1),
        .done  (done1)
    );

    // Model: a sweep is a count of completed run cycles; the stage is that count divided by the hold.
    int mN[2] = '{8, 4};
    int mH[2] = '{1, 3};
    bit mActive[2];
    bit mFrozen[2];
    bit mDone[2];
    int mProg[2];

    typedef struct {
        logic       start;
        logic       halt;
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[12];

    task automatic compareVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mActive[k] = 0;
            mFrozen[k] = 0;
            mDone[k]   = 0;
            mProg[k]   = 0;
        end
    endtask

    task automatic modelEdge();
        bit ab;
`ifdef SEQ_ABORT_EN
        ab = abort;
`else
        ab = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            mDone[k] = 0;
            if (!mActive[k]) begin
                if (start) begin
                    mActive[k] = 1;
                    mFrozen[k] = halt;
                    mProg[k]   = 0;
                end
            end else if (ab) begin
                mActive[k] = 0;
                mFrozen[k] = 0;
                mProg[k]   = 0;
            end else if (halt) begin
                mFrozen[k] = 1;
            end else if (mFrozen[k]) begin
                mFrozen[k] = 0;
            end else if (mProg[k] == mN[k] * mH[k] - 1) begin
                mDone[k]   = 1;
                mActive[k] = 0;
                mProg[k]   = 0;
            end else begin
                mProg[k]++;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int k = 0; k < 2; k++) begin
            int eSel;
            eSel = mActive[k] ? mProg[k] / mH[k] : 0;
            compareVal($sformatf("%s_d%0d_sel", tag, k), int'(k == 0 ? sel0 : sel1), eSel);
            compareVal($sformatf("%s_d%0d_en", tag, k), int'(k == 0 ? en0 : en1),
                       int'(mActive[k] && !mFrozen[k]));
            compareVal($sformatf("%s_d%0d_busy", tag, k), int'(k == 0 ? busy0 : busy1),
                       int'(mActive[k]));
            compareVal($sformatf("%s_d%0d_done", tag, k), int'(k == 0 ? done0 : done1),
                       int'(mDone[k]));
        end
    endtask

    task automatic applyStimulus(input bit s, input bit h, input bit a, input string tag);
        start = s;
        halt  = h;
        abort = a;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic runUntilIdle(input string tag, input int budget);
        int n;
        n = 0;
        while ((mActive[0] || mActive[1]) && n < budget) begin
            applyStimulus(0, 0, 0, tag);
            n++;
        end
        if (mActive[0] || mActive[1]) begin
            errors++;
            $display("[TB] FAIL %s_timeout actual=busy required=idle within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        int enCnt0, enCnt1, doneCnt0, doneCnt1;
        rst_n = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        abort = 1'b0;
        modelReset();
        #12;
        checkOutput("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Default instance, one full sweep with ignored start pulses, then start-under-halt.
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        for (int i = 1; i < 8; i++)
            vecs[i] = '{(i == 3 || i == 5) ? 1'b1 : 1'b0, 1'b0, 3'(i), 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].start, vecs[i].halt, 1'b0, $sformatf("vec%0d", i));
            compareVal($sformatf("tbl%0d_sel", i), int'(sel0), int'(vecs[i].sel));
            compareVal($sformatf("tbl%0d_en", i), int'(en0), int'(vecs[i].en));
            compareVal($sformatf("tbl%0d_busy", i), int'(busy0), int'(vecs[i].busy));
            compareVal($sformatf("tbl%0d_done", i), int'(done0), int'(vecs[i].done));
        end
        runUntilIdle("drain0", 100);

        // Clean sweep on both instances: count enabled cycles and done pulses.
        enCnt0 = 0; enCnt1 = 0; doneCnt0 = 0; doneCnt1 = 0;
        applyStimulus(1, 0, 0, "sweep");
        for (int c = 0; c < 14; c++) begin
            enCnt0 += int'(en0);
            enCnt1 += int'(en1);
            doneCnt0 += int'(done0);
            doneCnt1 += int'(done1);
            applyStimulus(0, 0, 0, "sweep");
        end
        compareVal("sweep_d0_en_cycles", enCnt0, 8);
        compareVal("sweep_d1_en_cycles", enCnt1, 12);
        compareVal("sweep_d0_done_pulses", doneCnt0, 1);
        compareVal("sweep_d1_done_pulses", doneCnt1, 1);

        // Halt for five cycles while the default instance shows stage 3.
        applyStimulus(1, 0, 0, "halt3");
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, "halt3");
        compareVal("halt3_pre_sel", int'(sel0), 3);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 1, 0, "halt3");
            compareVal("halt3_frozen_sel", int'(sel0), 3);
            compareVal("halt3_frozen_en", int'(en0), 0);
        end
        applyStimulus(0, 0, 0, "halt3");
        compareVal("halt3_resume_sel", int'(sel0), 3);
        compareVal("halt3_resume_en", int'(en0), 1);
        runUntilIdle("halt3", 100);

        // Halt on the last stage, with start pulses that must be ignored.
        applyStimulus(1, 0, 0, "halt7");
        for (int c = 0; c < 7; c++) applyStimulus(c[0], 0, 0, "halt7");
        compareVal("halt7_pre_sel", int'(sel0), 7);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 1, 0, "halt7");
            compareVal("halt7_no_done", int'(done0), 0);
        end
        applyStimulus(0, 0, 0, "halt7");
        compareVal("halt7_resume_sel", int'(sel0), 7);
        applyStimulus(0, 0, 0, "halt7");
        compareVal("halt7_done", int'(done0), 1);
        runUntilIdle("halt7", 100);

`ifdef SEQ_ABORT_EN
        applyStimulus(1, 0, 0, "abort");
        applyStimulus(0, 0, 0, "abort");
        applyStimulus(0, 0, 0, "abort");
        compareVal("abort_pre_sel", int'(sel0), 2);
        applyStimulus(0, 0, 1, "abort");
        compareVal("abort_busy", int'(busy0), 0);
        compareVal("abort_done", int'(done0), 0);
        applyStimulus(0, 0, 0, "abort");
        compareVal("abort_no_late_done", int'(done0), 0);
`endif

        // Asynchronous reset mid-sweep, checked before any further clock edge.
        applyStimulus(1, 0, 0, "rst");
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, "rst");
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async");
        compareVal("rst_async_en0", int'(en0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            bit s, h, a;
            s = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 4) == 0);
`ifdef SEQ_ABORT_EN
            a = ($urandom_range(0, 15) == 0);
`else
            a = 1'b0;
`endif
            if (a) s = 1'b0;
            applyStimulus(s, h, a, "rand");
        end
        runUntilIdle("rand", 200);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
